reg_file_mp: RTL

Parametrised multi-port register file for the pipeline's decode stage, successor to the two-read/one-write `reg_file`. Provides NUM_RD read ports, two write ports with fixed priority, an optional hardwired zero register, and a per-register busy scoreboard. Decode uses the scoreboard to detect RAW hazards against in-flight producers. Writes commit on the rising edge and reads register on the falling edge, so a value written in a cycle is readable in that same cycle.

---
 rtl/reg_file_mp.sv | 120 ++++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with write priority and busy scoreboard
//
// Purpose:
//   Decode-stage register file. Two write ports commit on the rising edge
//   (port 1 has priority on an address clash). NUM_RD read ports register
//   data and busy flags on the falling edge, so a value written in a cycle
//   is visible on rd in that same cycle. A per-register busy bit tracks
//   in-flight producers for RAW hazard detection.
//
// Ports:
//   clk       clock; writes/reserves on rising edge, reads on falling edge
//   reset     synchronous active-low reset, sampled on both edges
//   we0/wa0/wd0  write port 0
//   we1/wa1/wd1  write port 1 (wins when both ports target one address)
//   rsv_en/rsv_addr  mark a register busy for a newly issued producer
//   ra        packed read addresses, port k at ra[k*ADDR_W +: ADDR_W]
//   rd        packed registered read data, port k at rd[k*DATA_W +: DATA_W]
//   rbusy     registered busy flag per read port
module reg_file_mp #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [DATA_W-1:0]          wd0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd1,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  output logic [NUM_RD-1:0]          rbusy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]         r_busy;
  logic [NUM_RD*DATA_W-1:0] r_rd;
  logic [NUM_RD-1:0]        r_rbusy;

  logic                     w_wr0_ok;
  logic                     w_wr1_ok;
  logic                     w_rsv_ok;
  logic [DEPTH-1:0]         w_busy_nxt;
  logic [DATA_W-1:0]        w_rd_data [NUM_RD];
  logic                     w_rd_busy [NUM_RD];

  // Reset image of one entry; register 0 is forced to zero when hardwired.
  function automatic logic [DATA_W-1:0] init_val(input int idx);
    logic [31:0] v;
    v = 32'(idx);
    if ((ZERO_REG != 0) && (idx == 0)) return '0;
    if (INIT_INDEX != 0) return DATA_W'(v);
    return '0;
  endfunction

  // Accesses to a hardwired zero register are dropped at the source.
  assign w_wr0_ok = we0 && !((ZERO_REG != 0) && (wa0 == '0));
  assign w_wr1_ok = we1 && !((ZERO_REG != 0) && (wa1 == '0));
  assign w_rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Writes retire producers, then a same-cycle reserve re-marks the
  // register: that reserve belongs to a newer producer, so it must win.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr0_ok) w_busy_nxt[wa0] = 1'b0;
    if (w_wr1_ok) w_busy_nxt[wa1] = 1'b0;
    if (w_rsv_ok) w_busy_nxt[rsv_addr] = 1'b1;
  end

  // Port 1 is written last so it takes priority on an address clash.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= init_val(i);
      end
      r_busy <= '0;
    end else begin
      if (w_wr0_ok) r_mem[wa0] <= wd0;
      if (w_wr1_ok) r_mem[wa1] <= wd1;
      r_busy <= w_busy_nxt;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      w_rd_data[k] = r_mem[ra[k*ADDR_W +: ADDR_W]];
      w_rd_busy[k] = r_busy[ra[k*ADDR_W +: ADDR_W]];
      if ((ZERO_REG != 0) && (ra[k*ADDR_W +: ADDR_W] == '0)) begin
        w_rd_data[k] = '0;
        w_rd_busy[k] = 1'b0;
      end
    end
  end

  // Falling-edge read stage: sees everything committed on the preceding
  // rising edge of the same cycle.
  always_ff @(negedge clk) begin
    if (!reset) begin
      r_rd    <= '0;
      r_rbusy <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        r_rd[k*DATA_W +: DATA_W] <= w_rd_data[k];
        r_rbusy[k]               <= w_rd_busy[k];
      end
    end
  end

  assign rd    = r_rd;
  assign rbusy = r_rbusy;

endmodule
